// File: rtl/pixel_dispatch_sched.sv
// Round-robin dispatcher of rasterised pixels from NoR sources onto NoS shader threads,
// with per-thread launch reservation, watchdog and frame drain tracking.
`timescale 1ns/1ps
module pixel_dispatch_sched #(
   parameter int unsigned NoR  = 2,
   parameter int unsigned NoS  = 4,
   parameter int unsigned CW   = 12,
   parameter int unsigned TMOW = 8,
   parameter int unsigned CNTW = 24
) (
   input  logic                core_clock_i,
   input  logic                core_reset_i,
   input  logic                enable_i,
   input  logic [NoR-1:0]      src_valid_i,
   input  logic [CW*NoR-1:0]   src_x_i,
   input  logic [CW*NoR-1:0]   src_y_i,
   output logic [NoR-1:0]      src_ready_o,
   input  logic [NoS-1:0]      thrend_state_i,
   output logic [NoS-1:0]      reset_o,
   output logic [NoS-1:0]      write_coords_o,
   output logic [CW-1:0]       int_coord_x_o,
   output logic [CW-1:0]       int_coord_y_o,
   input  logic                frame_end_i,
   output logic                frame_done_o,
   output logic [CNTW-1:0]     dispatch_cnt_o,
   output logic                err_timeout_o
);

   localparam int unsigned SPW = (NoR > 1) ? $clog2(NoR) : 1;
   localparam int unsigned TPW = (NoS > 1) ? $clog2(NoS) : 1;
   // Counter value one short of 2**TMOW-1: the increment that would reach it expires instead.
   localparam logic [TMOW-1:0] WD_LAST = ~TMOW'(1);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t                   state;
   logic [SPW-1:0]           src_ptr, src_sel, s_idx;
   logic [TPW-1:0]           thr_ptr, thr_sel, t_idx;
   logic                     src_hit, thr_hit, grant, drained;
   logic [NoS-1:0]           reserved, elig;
   logic [NoS-1:0][TMOW-1:0] wd;
   logic [CW-1:0]            pix_x, pix_y;

   assign elig    = thrend_state_i & ~reserved;
   assign grant   = enable_i && src_hit && thr_hit && (state != DONE);
   assign pix_x   = src_x_i[CW*src_sel +: CW];
   assign pix_y   = src_y_i[CW*src_sel +: CW];
   assign drained = !(|src_valid_i) && (&thrend_state_i) && !(|reserved) && !(|reset_o);
   assign write_coords_o = reset_o;

   always_comb begin
      src_hit = 1'b0;
      src_sel = '0;
      s_idx   = '0;
      for (int unsigned i = 0; i < NoR; i++) begin
         s_idx = SPW'((32'(src_ptr) + i) % NoR);
         if (!src_hit && src_valid_i[s_idx]) begin
            src_hit = 1'b1;
            src_sel = s_idx;
         end
      end
   end

   always_comb begin
      thr_hit = 1'b0;
      thr_sel = '0;
      t_idx   = '0;
      for (int unsigned i = 0; i < NoS; i++) begin
         t_idx = TPW'((32'(thr_ptr) + i) % NoS);
         if (!thr_hit && elig[t_idx]) begin
            thr_hit = 1'b1;
            thr_sel = t_idx;
         end
      end
   end

   always_comb begin
      src_ready_o = '0;
      if (grant) src_ready_o[src_sel] = 1'b1;
   end

   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         src_ptr       <= '0;
         thr_ptr       <= '0;
         reset_o       <= '0;
         int_coord_x_o <= '0;
         int_coord_y_o <= '0;
      end else begin
         reset_o <= '0;
         if (grant) begin
            reset_o[thr_sel] <= 1'b1;
            int_coord_x_o    <= pix_x;
            int_coord_y_o    <= pix_y;
            src_ptr <= (src_sel == SPW'(NoR - 1)) ? '0 : src_sel + SPW'(1);
            thr_ptr <= (thr_sel == TPW'(NoS - 1)) ? '0 : thr_sel + TPW'(1);
         end
      end
   end

   // A busy indication is ignored while this thread's launch strobe is still on the wire.
   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         reserved      <= '0;
         wd            <= '0;
         err_timeout_o <= 1'b0;
      end else begin
         for (int unsigned t = 0; t < NoS; t++) begin
            if (grant && (thr_sel == TPW'(t))) begin
               reserved[t] <= 1'b1;
               wd[t]       <= '0;
            end else if (reserved[t]) begin
               if (!thrend_state_i[t]) begin
                  if (!reset_o[t]) begin
                     reserved[t] <= 1'b0;
                     wd[t]       <= '0;
                  end
               end else if (wd[t] == WD_LAST) begin
                  reserved[t]   <= 1'b0;
                  wd[t]         <= '0;
                  err_timeout_o <= 1'b1;
               end else begin
                  wd[t] <= wd[t] + TMOW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         state          <= RUN;
         frame_done_o   <= 1'b0;
         dispatch_cnt_o <= '0;
      end else begin
         frame_done_o <= 1'b0;
         if (grant) dispatch_cnt_o <= dispatch_cnt_o + CNTW'(1);
         case (state)
            RUN: begin
               if (frame_end_i) state <= DRAIN;
            end
            DRAIN: begin
               if (drained) begin
                  state        <= DONE;
                  frame_done_o <= 1'b1;
               end
            end
            DONE: begin
               dispatch_cnt_o <= '0;
               state          <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_dispatch_sched.sv
// Scoreboard bench for pixel_dispatch_sched: stimulus pushes expected launches, a monitor pops them.
`timescale 1ns/1ps
module tb_pixel_dispatch_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        fe = 1'b0;
   logic [1:0]  valid = '0;
   logic [3:0]  thrend = '0;
   logic [11:0] px0 = '0, py0 = '0, px1 = '0, py1 = '0;
   logic [11:0] nx0 = '0, ny0 = '0, nx1 = '0, ny1 = '0;

   logic [1:0]  src_ready;
   logic [3:0]  thr_reset, thr_wr;
   logic [11:0] cx, cy;
   logic        frame_done, err_to;
   logic [23:0] cnt;

   int checks = 0;
   int errors = 0;
   logic [27:0] exp_q[$];

   always #5 clk = ~clk;

   pixel_dispatch_sched #(
      .NoR(2), .NoS(4), .CW(12), .TMOW(8), .CNTW(24)
   ) dut (
      .core_clock_i   (clk),
      .core_reset_i   (rst),
      .enable_i       (en),
      .src_valid_i    (valid),
      .src_x_i        ({px1, px0}),
      .src_y_i        ({py1, py0}),
      .src_ready_o    (src_ready),
      .thrend_state_i (thrend),
      .reset_o        (thr_reset),
      .write_coords_o (thr_wr),
      .int_coord_x_o  (cx),
      .int_coord_y_o  (cy),
      .frame_end_i    (fe),
      .frame_done_o   (frame_done),
      .dispatch_cnt_o (cnt),
      .err_timeout_o  (err_to)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [3:0] te, input logic e, input logic f);
      valid = v; thrend = te; en = e; fe = f;
      px0 = nx0; py0 = ny0; px1 = nx1; py1 = ny1;
   endtask

   // One cycle: apply inputs after the edge, check the grant mid-cycle, queue the expected launch.
   task automatic step(input logic [1:0] v, input logic [3:0] te, input logic e, input logic f,
                       input logic [1:0] xr, input logic [3:0] xt);
      @(posedge clk); #1;
      drive(v, te, e, f);
      @(negedge clk);
      chk("src_ready", 32'(src_ready), 32'(xr));
      if (xr == 2'b01)      exp_q.push_back({xt, px0, py0});
      else if (xr == 2'b10) exp_q.push_back({xt, px1, py1});
   endtask

   always @(negedge clk) begin
      logic [27:0] e;
      if (thr_wr != '0 || thr_reset != '0) begin
         chk("strobe_pair", 32'(thr_reset), 32'(thr_wr));
         if (exp_q.size() == 0) begin
            chk("strobe_unexpected", 32'(thr_wr), 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_thread", 32'(thr_wr), 32'(e[27:24]));
            chk("strobe_x", 32'(cx), 32'(e[23:12]));
            chk("strobe_y", 32'(cy), 32'(e[11:0]));
         end
      end
   end

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_ready", 32'(src_ready), 32'h0);
      chk("rst_thr_reset", 32'(thr_reset), 32'h0);
      chk("rst_coords", 32'({cx, cy}), 32'h0);
      chk("rst_done", 32'(frame_done), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
      chk("rst_err", 32'(err_to), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);

      // Enable low grants nothing, then T1 single dispatch
      nx0 = 12'd5; ny0 = 12'd7;
      step(2'b01, 4'b1111, 1'b0, 1'b0, 2'b00, 4'b0000);
      step(2'b01, 4'b1111, 1'b1, 1'b0, 2'b01, 4'b0001);
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b00, 4'b1110, 1'b1, 1'b0, 2'b00, 4'b0000);
      chk("coord_hold", 32'({cx, cy}), {8'h0, 12'd5, 12'd7});
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);

      // T2 both sources valid: src ptr is 1, thread ptr is 1
      for (int i = 1; i <= 4; i++) begin
         nx0 = 12'(100 + i); ny0 = 12'(200 + i); nx1 = 12'(300 + i); ny1 = 12'(400 + i);
         step(2'b11, 4'b1111, 1'b1, 1'b0, (i % 2 == 1) ? 2'b10 : 2'b01, 4'(1 << (i % 4)));
      end
      step(2'b11, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b00, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);

      // T4 all threads busy, then only thread 3 frees
      step(2'b01, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b01, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);
      nx0 = 12'd55; ny0 = 12'd66;
      step(2'b01, 4'b1000, 1'b1, 1'b0, 2'b01, 4'b1000);
      step(2'b00, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b00, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);
      chk("cnt_six", 32'(cnt), 32'd6);

      // T3 watchdog on thread 2
      nx0 = 12'd9; ny0 = 12'd11;
      step(2'b01, 4'b0100, 1'b1, 1'b0, 2'b01, 4'b0100);
      for (int k = 1; k <= 255; k++) step(2'b01, 4'b0100, 1'b1, 1'b0, 2'b00, 4'b0000);
      chk("err_before_expiry", 32'(err_to), 32'h0);
      nx0 = 12'd12; ny0 = 12'd13;
      step(2'b01, 4'b0100, 1'b1, 1'b0, 2'b01, 4'b0100);
      chk("err_at_expiry", 32'(err_to), 32'h1);
      step(2'b00, 4'b0100, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b00, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);
      chk("err_sticky", 32'(err_to), 32'h1);

      // T6 reset on a grant cycle (src ptr 1, thread ptr 3); the launch is dropped
      nx0 = 12'd1; ny0 = 12'd2; nx1 = 12'd3; ny1 = 12'd4;
      @(posedge clk); #1;
      drive(2'b11, 4'b1111, 1'b1, 1'b0);
      @(negedge clk);
      chk("t6_ready", 32'(src_ready), 32'h2);
      #1 rst = 1'b1;
      valid = 2'b00;
      @(negedge clk);
      chk("t6_thr_reset", 32'(thr_reset), 32'h0);
      chk("t6_thr_wr", 32'(thr_wr), 32'h0);
      chk("t6_coords", 32'({cx, cy}), 32'h0);
      chk("t6_err", 32'(err_to), 32'h0);
      chk("t6_cnt", 32'(cnt), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      nx0 = 12'd21; ny0 = 12'd22;
      step(2'b11, 4'b1111, 1'b1, 1'b0, 2'b01, 4'b0001);
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);
      step(2'b00, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);

      // T5 nine more pixels (ten in the frame), frame end on the last grant
      for (int k = 1; k <= 9; k++) begin
         nx0 = 12'(k * 3); ny0 = 12'(k * 5 + 1);
         step(2'b01, 4'b1111, 1'b1, (k == 9), 2'b01, 4'(1 << (k % 4)));
         step(2'b00, 4'b1111, 1'b1, (k == 9), 2'b00, 4'b0000);
         step(2'b00, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);
      end
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);
      chk("done_not_yet", 32'(frame_done), 32'h0);
      step(2'b01, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);
      chk("done_pulse", 32'(frame_done), 32'h1);
      chk("cnt_ten", 32'(cnt), 32'd10);
      nx0 = 12'd77; ny0 = 12'd88;
      step(2'b01, 4'b1111, 1'b1, 1'b0, 2'b01, 4'b0100);
      chk("done_single", 32'(frame_done), 32'h0);
      chk("cnt_cleared", 32'(cnt), 32'h0);
      step(2'b00, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000);
      chk("cnt_new_frame", 32'(cnt), 32'h1);
      step(2'b00, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
